// File: rtl/rv_pkg.sv
// Shared core definitions: RV32I load/store funct3 codes and LSU FSM states.
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_RESP
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side op handshake, data-memory bus and writeback result of the LSU.
interface load_store_unit_if;

    logic        op_valid;
    logic        op_ready;
    logic        op_we;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;

    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        done;
    logic        err;
    logic [31:0] load_data;

    // master: execute stage plus data memory; slave: the LSU itself
    modport master (
        output op_valid, op_we, op_funct3, op_addr, op_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  op_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  done, err, load_data
    );

    modport slave (
        input  op_valid, op_we, op_funct3, op_addr, op_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output op_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output done, err, load_data
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane formatting: byte enables, store replication, load extraction.
// LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are flagged illegal.
module lsu_align
    import rv_pkg::*;
(
    input  logic        st_we,
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_wdata,
    output logic [1:0]  st_off,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_rep,
    output logic        st_illegal,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_value
);

    logic        bad_f3;
    logic        bad_st;
    logic [31:0] sh;

    always_comb begin
        st_off       = st_lo;
        st_be        = 4'b0000;
        st_wdata_rep = st_wdata;
        bad_f3       = 1'b0;
        unique case (st_funct3)
            F3_B, F3_BU: begin
                st_be        = 4'b0001 << st_lo;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                st_off       = {st_lo[1], 1'b0};
                st_be        = 4'b0011 << {st_lo[1], 1'b0};
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            F3_W: begin
                st_off = 2'b00;
                st_be  = 4'b1111;
            end
            default: bad_f3 = 1'b1;
        endcase
    end

    assign bad_st = st_we && (st_funct3 == F3_BU || st_funct3 == F3_HU);

`ifdef LSU_MISALIGN_TRAP_EN
    // forced alignment differs from the raw offset exactly when misaligned
    assign st_illegal = bad_f3 | bad_st | (st_off != st_lo);
`else
    assign st_illegal = bad_f3 | bad_st;
`endif

    assign sh = ld_rdata >> {ld_off, 3'b000};

    always_comb begin
        ld_value = sh;
        unique case (ld_funct3)
            F3_B:    ld_value = {{24{sh[7]}}, sh[7:0]};
            F3_H:    ld_value = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   ld_value = {24'h0, sh[7:0]};
            F3_HU:   ld_value = {16'h0, sh[15:0]};
            default: ld_value = sh;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store per handshake over a req/gnt/rvalid bus.
// LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of forcing alignment.
module load_store_unit (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);
    import rv_pkg::*;

    lsu_state_t  state;
    lsu_state_t  state_nxt;

    logic        accept;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] ld_q;

    logic [1:0]  a_off;
    logic [3:0]  a_be;
    logic [31:0] a_wdata;
    logic        a_illegal;
    logic [31:0] a_ld;

    lsu_align u_align (
        .st_we        (bus.op_we),
        .st_funct3    (bus.op_funct3),
        .st_lo        (bus.op_addr[1:0]),
        .st_wdata     (bus.op_wdata),
        .st_off       (a_off),
        .st_be        (a_be),
        .st_wdata_rep (a_wdata),
        .st_illegal   (a_illegal),
        .ld_funct3    (r_f3),
        .ld_off       (r_off),
        .ld_rdata     (bus.mem_rdata),
        .ld_value     (a_ld)
    );

    assign accept = bus.op_valid && (state == LSU_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LSU_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LSU_IDLE: begin
                if (accept) state_nxt = a_illegal ? LSU_RESP : LSU_REQ;
            end
            LSU_REQ: begin
                if (bus.mem_gnt) state_nxt = we_q ? LSU_RESP : LSU_WAIT;
            end
            LSU_WAIT: begin
                if (bus.mem_rvalid) state_nxt = LSU_RESP;
            end
            LSU_RESP: state_nxt = LSU_IDLE;
            default:  state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f3    <= 3'b000;
            r_off   <= 2'b00;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            ld_q    <= 32'h0;
        end else begin
            if (accept) begin
                r_f3    <= bus.op_funct3;
                r_off   <= a_off;
                we_q    <= bus.op_we;
                addr_q  <= {bus.op_addr[31:2], 2'b00};
                be_q    <= a_be;
                wdata_q <= a_wdata;
                err_q   <= a_illegal;
            end
            if (state == LSU_WAIT && bus.mem_rvalid) ld_q <= a_ld;
        end
    end

    assign bus.op_ready  = (state == LSU_IDLE);
    assign bus.mem_req   = (state == LSU_REQ);
    assign bus.done      = (state == LSU_RESP);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.err       = err_q;
    assign bus.load_data = ld_q;

endmodule
